// File: rtl/dtpu_pkg.sv
// rtl/dtpu_pkg.sv - shared constants and helpers for the MXU result packer
package dtpu_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

    function automatic int calc_lanes(input int dw_out, input int dw_mac);
        return dw_out / dw_mac;
    endfunction

    function automatic int calc_beats(input int columns, input int lanes);
        return (columns + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous vector FIFO with wrap-bit pointers
module result_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // A push while full is only legal when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer advance; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; the head is read combinationally before it can be overwritten.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mxu_result_packer.sv
// rtl/mxu_result_packer.sv - buffers MXU result vectors and serializes them to AXI-Stream
module mxu_result_packer
    import dtpu_pkg::*;
#(
    parameter int COLUMNS             = 3,
    parameter int DATA_WIDTH_MAC      = 32,
    parameter int DATA_WIDTH_FIFO_OUT = 64,
    parameter int DEPTH               = 4,
    parameter int PACKET_LEN          = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              glb_enable,
    input  logic                              outfifo_write,
    input  logic [COLUMNS*DATA_WIDTH_MAC-1:0] res_data,
    output logic                              outfifo_is_full,
    output logic [DATA_WIDTH_FIFO_OUT-1:0]    m_axis_tdata,
    output logic [DATA_WIDTH_FIFO_OUT/8-1:0]  m_axis_tkeep,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic                              overflow_err,
    input  logic                              clear_err,
    output logic [$clog2(DEPTH):0]            vec_count
);
    localparam int LANES = calc_lanes(DATA_WIDTH_FIFO_OUT, DATA_WIDTH_MAC);
    localparam int BEATS = calc_beats(COLUMNS, LANES);
    localparam int VW    = COLUMNS * DATA_WIDTH_MAC;
    localparam int KW    = DATA_WIDTH_FIFO_OUT / 8;
    localparam int LKW   = DATA_WIDTH_MAC / 8;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [PW-1:0] LAST_PKT  = PW'(PACKET_LEN - 1);

    ser_state_t                     state;
    logic [BW-1:0]                  beat;
    logic [PW-1:0]                  pkt_cnt;
    logic [VW-1:0]                  vec_q;
    logic                           tvalid_q;

    logic [VW-1:0]                  fifo_rdata;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [CW-1:0]                  fifo_count;
    logic                           hs;
    logic                           last_beat;
    logic                           can_load;
    logic                           pop;
    logic                           push;
    logic                           drop;
    logic [CW-1:0]                  count_next;
    logic [BEATS*DATA_WIDTH_FIFO_OUT-1:0] vec_pad;
    logic [BEATS*KW-1:0]            keep_pad;
    logic [DATA_WIDTH_FIFO_OUT-1:0] tdata_c;
    logic [KW-1:0]                  tkeep_c;

    assign hs        = tvalid_q && m_axis_tready;
    assign last_beat = (beat == LAST_BEAT);
    assign can_load  = !fifo_empty && glb_enable;
    assign pop       = ((state == ST_IDLE) && can_load) ||
                       ((state == ST_SEND) && hs && last_beat && can_load);
    assign push      = outfifo_write && (!fifo_full || pop);
    assign drop      = outfifo_write && fifo_full && !pop;
    assign count_next = fifo_count + CW'(push) - CW'(pop);

    result_fifo #(.WIDTH(VW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .wdata (res_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Zero-pad the vector to whole beats; lanes past COLUMNS carry no data and no strobes.
    always_comb begin
        vec_pad           = '0;
        vec_pad[VW-1:0]   = vec_q;
        keep_pad          = '0;
        for (int i = 0; i < COLUMNS * LKW; i++) keep_pad[i] = 1'b1;
        tdata_c = vec_pad[int'(beat)*DATA_WIDTH_FIFO_OUT +: DATA_WIDTH_FIFO_OUT];
        tkeep_c = keep_pad[int'(beat)*KW +: KW];
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tvalid_q ? tdata_c : '0;
    assign m_axis_tkeep  = tvalid_q ? tkeep_c : '0;
    assign m_axis_tlast  = tvalid_q && last_beat && (pkt_cnt == LAST_PKT);
    assign vec_count     = fifo_count;

    // Serializer: load a vector, step beats on handshake, chain the next vector without a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            beat     <= '0;
            pkt_cnt  <= '0;
            vec_q    <= '0;
            tvalid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (can_load) begin
                        vec_q    <= fifo_rdata;
                        beat     <= '0;
                        tvalid_q <= 1'b1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (hs) begin
                        if (!last_beat) begin
                            beat <= beat + BW'(1);
                        end else begin
                            beat    <= '0;
                            pkt_cnt <= (pkt_cnt == LAST_PKT) ? '0 : pkt_cnt + PW'(1);
                            if (can_load) begin
                                vec_q <= fifo_rdata;
                            end else begin
                                tvalid_q <= 1'b0;
                                state    <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Full flag tracks the post-edge occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) outfifo_is_full <= 1'b0;
        else        outfifo_is_full <= (count_next == CW'(DEPTH));
    end

    // Sticky overflow flag; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         overflow_err <= 1'b0;
        else if (drop)      overflow_err <= 1'b1;
        else if (clear_err) overflow_err <= 1'b0;
    end

endmodule

// File: tb/tb_mxu_result_packer.sv
// tb/tb_mxu_result_packer.sv - directed self-checking bench for mxu_result_packer
module tb_mxu_result_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        glb_enable = 1'b1;
    logic        outfifo_write = 1'b0;
    logic [95:0] res_data = '0;
    logic        m_axis_tready = 1'b1;
    logic        clear_err = 1'b0;
    logic        use4 = 1'b0;

    logic        d1_full, d1_tvalid, d1_tlast, d1_ovf;
    logic [63:0] d1_tdata;
    logic [7:0]  d1_tkeep;
    logic [2:0]  d1_cnt;
    logic        d4_full, d4_tvalid, d4_tlast, d4_ovf;
    logic [63:0] d4_tdata;
    logic [7:0]  d4_tkeep;
    logic [2:0]  d4_cnt;

    logic        o_full, o_tvalid, o_tlast, o_ovf;
    logic [63:0] o_tdata;
    logic [7:0]  o_tkeep;
    logic [2:0]  o_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mxu_result_packer #(.PACKET_LEN(1)) u_dut1 (
        .clk(clk), .reset(reset), .glb_enable(glb_enable), .outfifo_write(outfifo_write),
        .res_data(res_data), .outfifo_is_full(d1_full), .m_axis_tdata(d1_tdata),
        .m_axis_tkeep(d1_tkeep), .m_axis_tvalid(d1_tvalid), .m_axis_tlast(d1_tlast),
        .m_axis_tready(m_axis_tready), .overflow_err(d1_ovf), .clear_err(clear_err),
        .vec_count(d1_cnt)
    );

    mxu_result_packer #(.PACKET_LEN(4)) u_dut4 (
        .clk(clk), .reset(reset), .glb_enable(glb_enable), .outfifo_write(outfifo_write),
        .res_data(res_data), .outfifo_is_full(d4_full), .m_axis_tdata(d4_tdata),
        .m_axis_tkeep(d4_tkeep), .m_axis_tvalid(d4_tvalid), .m_axis_tlast(d4_tlast),
        .m_axis_tready(m_axis_tready), .overflow_err(d4_ovf), .clear_err(clear_err),
        .vec_count(d4_cnt)
    );

    assign o_full   = use4 ? d4_full   : d1_full;
    assign o_tvalid = use4 ? d4_tvalid : d1_tvalid;
    assign o_tlast  = use4 ? d4_tlast  : d1_tlast;
    assign o_ovf    = use4 ? d4_ovf    : d1_ovf;
    assign o_tdata  = use4 ? d4_tdata  : d1_tdata;
    assign o_tkeep  = use4 ? d4_tkeep  : d1_tkeep;
    assign o_cnt    = use4 ? d4_cnt    : d1_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int i, input int c);
        return {8'(i + 1), 8'hA5, 8'h00, 8'(c)};
    endfunction

    task automatic write_vec(input int i);
        res_data      = {mk(i, 2), mk(i, 1), mk(i, 0)};
        outfifo_write = 1'b1;
        tick();
        outfifo_write = 1'b0;
    endtask

    task automatic do_reset();
        outfifo_write = 1'b0;
        clear_err     = 1'b0;
        reset         = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Expects nvec vectors (ids first..) as contiguous beats with tready=1.
    task automatic drain(input int nvec, input int first, input int plen, input string tag);
        int w;
        w = 0;
        while (!o_tvalid && w < 20) begin
            tick();
            w++;
        end
        check({tag, " start"}, 64'(o_tvalid), 64'd1);
        for (int k = 0; k < 2 * nvec; k++) begin
            int v;
            logic [63:0] ed;
            v  = first + k / 2;
            ed = (k % 2 == 0) ? {mk(v, 1), mk(v, 0)} : {32'h0, mk(v, 2)};
            check($sformatf("%s tvalid b%0d", tag, k), 64'(o_tvalid), 64'd1);
            check($sformatf("%s tdata b%0d", tag, k), o_tdata, ed);
            check($sformatf("%s tkeep b%0d", tag, k), 64'(o_tkeep), (k % 2 == 1) ? 64'h0F : 64'hFF);
            check($sformatf("%s tlast b%0d", tag, k), 64'(o_tlast),
                  64'((k % 2 == 1) && ((k / 2) % plen == plen - 1)));
            tick();
        end
        check({tag, " end"}, 64'(o_tvalid), 64'd0);
    endtask

    initial begin
        logic [63:0] hold_d;
        // Reset state
        tick();
        check("rst tvalid", 64'(d1_tvalid), 0);
        check("rst tdata", d1_tdata, 0);
        check("rst tkeep", 64'(d1_tkeep), 0);
        check("rst tlast", 64'(d1_tlast), 0);
        check("rst full", 64'(d1_full), 0);
        check("rst ovf", 64'(d1_ovf), 0);
        check("rst cnt", 64'(d1_cnt), 0);
        check("rst tvalid4", 64'(d4_tvalid), 0);
        reset = 1'b1;
        tick();

        // Single vector latency and packing
        res_data      = 96'h33333333_22222222_11111111;
        outfifo_write = 1'b1;
        tick();
        outfifo_write = 1'b0;
        check("lat N+1 tvalid", 64'(o_tvalid), 0);
        tick();
        check("lat N+2 tvalid", 64'(o_tvalid), 1);
        check("single b0 tdata", o_tdata, 64'h2222222211111111);
        check("single b0 tkeep", 64'(o_tkeep), 64'hFF);
        check("single b0 tlast", 64'(o_tlast), 0);
        tick();
        check("single b1 tdata", o_tdata, 64'h0000000033333333);
        check("single b1 tkeep", 64'(o_tkeep), 64'h0F);
        check("single b1 tlast", 64'(o_tlast), 1);
        tick();
        check("single done", 64'(o_tvalid), 0);

        // Backpressure on beat 0
        do_reset();
        m_axis_tready = 1'b0;
        res_data      = 96'hCCCC0003_BBBB0002_AAAA0001;
        outfifo_write = 1'b1;
        tick();
        outfifo_write = 1'b0;
        tick();
        hold_d = 64'hBBBB0002AAAA0001;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp tvalid c%0d", i), 64'(o_tvalid), 1);
            check($sformatf("bp tdata c%0d", i), o_tdata, hold_d);
            check($sformatf("bp tkeep c%0d", i), 64'(o_tkeep), 64'hFF);
            check($sformatf("bp tlast c%0d", i), 64'(o_tlast), 0);
            tick();
        end
        m_axis_tready = 1'b1;
        tick();
        check("bp b1 tdata", o_tdata, 64'h00000000CCCC0003);
        check("bp b1 tlast", 64'(o_tlast), 1);
        tick();
        check("bp done", 64'(o_tvalid), 0);

        // Overflow with the serializer held off
        do_reset();
        glb_enable    = 1'b0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) write_vec(i);
        check("ovf full after 4", 64'(o_full), 1);
        check("ovf cnt after 4", 64'(o_cnt), 4);
        check("ovf err after 4", 64'(o_ovf), 0);
        write_vec(4);
        write_vec(5);
        check("ovf err after 6", 64'(o_ovf), 1);
        check("ovf cnt after 6", 64'(o_cnt), 4);
        glb_enable    = 1'b1;
        m_axis_tready = 1'b1;
        drain(4, 0, 1, "ovf drain");
        check("ovf cnt drained", 64'(o_cnt), 0);
        check("ovf full drained", 64'(o_full), 0);
        check("ovf err sticky", 64'(o_ovf), 1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("ovf err cleared", 64'(o_ovf), 0);

        // Write while full on the pop cycle
        do_reset();
        glb_enable = 1'b0;
        for (int i = 0; i < 4; i++) write_vec(i);
        check("fp full before", 64'(o_full), 1);
        glb_enable    = 1'b1;
        res_data      = {mk(4, 2), mk(4, 1), mk(4, 0)};
        outfifo_write = 1'b1;
        tick();
        outfifo_write = 1'b0;
        check("fp cnt", 64'(o_cnt), 4);
        check("fp full", 64'(o_full), 1);
        check("fp ovf", 64'(o_ovf), 0);
        drain(5, 0, 1, "fp drain");

        // Packets of four vectors, gated start
        use4 = 1'b1;
        do_reset();
        glb_enable = 1'b0;
        for (int i = 0; i < 4; i++) write_vec(i);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("gate tvalid c%0d", i), 64'(o_tvalid), 0);
            tick();
        end
        check("gate cnt", 64'(o_cnt), 4);
        glb_enable = 1'b1;
        drain(4, 0, 4, "pkt4");

        // Reset during beat 0 of the second vector
        do_reset();
        glb_enable = 1'b0;
        for (int i = 0; i < 4; i++) write_vec(i);
        glb_enable = 1'b1;
        tick();
        check("mr v0 b0", o_tdata, {mk(0, 1), mk(0, 0)});
        tick();
        tick();
        check("mr v1 b0", o_tdata, {mk(1, 1), mk(1, 0)});
        reset = 1'b0;
        #1;
        check("mr tvalid", 64'(o_tvalid), 0);
        check("mr cnt", 64'(o_cnt), 0);
        check("mr tlast", 64'(o_tlast), 0);
        tick();
        reset = 1'b1;
        tick();
        glb_enable = 1'b0;
        for (int i = 10; i < 14; i++) write_vec(i);
        glb_enable = 1'b1;
        drain(4, 10, 4, "mr fresh");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
